perf_event_monitor: RTL

- Synthesizable pipeline performance monitor for the 5-stage CPU.
- Counts active cycles and up to NUM_EVT qualified pipeline events, such as load-use stalls and branch flushes.
- Provides a cycle budget that stops counting automatically, plus a registered readout port for debug and testbench use.
- Sits beside the CPU top and taps hazard-unit and control outputs through plain 1-bit event wires.

---
 rtl/perf_pkg.sv | 22 ++
 rtl/perf_sat_counter.sv | 39 +++
 rtl/perf_event_monitor.sv | 139 +++++++++++++
 3 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the pipeline performance monitor.
// Contents:
//   perf_state_e : monitor FSM state encoding.
//   SEL_CYCLE    : readout select value of the cycle counter.
//   sel_w()      : readout select width for a given number of event channels.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } perf_state_e;

    localparam int SEL_CYCLE = 0;

    // Select values are 0..num_evt (cycle counter plus one per channel).
    function automatic int sel_w(input int num_evt);
        return $clog2(num_evt + 1);
    endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating counter with enable, synchronous clear and sticky overflow.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clr_i          : synchronous clear of count and overflow flag
//   en_i           : increment request for this edge
//   cnt_o          : current count (holds at all-ones)
//   ovf_o          : set when an increment is requested at all-ones; sticky
module perf_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         ovf_o
);

    logic [W-1:0] cnt_q;
    logic         ovf_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (en_i) begin
            // No wrap: a refused increment is what flags overflow.
            if (&cnt_q) ovf_q <= 1'b1;
            else        cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_event_monitor.sv
// Pipeline performance monitor: counts RUN cycles and NUM_EVT vetoable
// event channels, stops at a cycle budget, and offers a registered readout.
// Optional feature macro: PERF_SNAPSHOT_EN (adds snap_i and shadow readout).
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   start_i        : level enable; counting only while high
//   clear_i        : synchronous clear of counters, flags, readout and FSM
//   evt_i          : raw event pulses, bit k = channel k
//   evt_veto_i     : per-channel veto, channel k counts evt_i[k] & ~evt_veto_i[k]
//   snap_i         : (PERF_SNAPSHOT_EN only) copy all counters to shadows
//   rd_sel_i       : 0 = cycle counter, k+1 = channel k, > NUM_EVT reads 0
//   rd_data_o      : registered readout, one cycle behind rd_sel_i
//   ovf_o          : sticky saturation flags, bit 0 = cycles, bit k+1 = channel k
//   running_o      : FSM in RUN
//   done_o         : FSM in DONE
module perf_event_monitor
    import perf_pkg::*;
#(
    parameter int NUM_EVT    = 2,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 30
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        start_i,
    input  logic                        clear_i,
    input  logic [NUM_EVT-1:0]          evt_i,
    input  logic [NUM_EVT-1:0]          evt_veto_i,
`ifdef PERF_SNAPSHOT_EN
    input  logic                        snap_i,
`endif
    input  logic [sel_w(NUM_EVT)-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]            rd_data_o,
    output logic [NUM_EVT:0]            ovf_o,
    output logic                        running_o,
    output logic                        done_o
);

    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_CYCLES);

    perf_state_e               state_q;
    logic                      running_q;
    logic                      done_q;
    logic [CNT_W-1:0]          rd_data_q;
    logic [CNT_W-1:0]          rd_data_d;
    logic [NUM_EVT:0][CNT_W-1:0] cnt;
    logic [NUM_EVT:0][CNT_W-1:0] src;
    logic [NUM_EVT:0]          inc;
    logic                      cnt_en;
    logic                      hit_max;

    // The edge that enters RUN already counts, so enable depends on start_i
    // rather than on being in RUN; DONE never counts.
    assign cnt_en = start_i && !clear_i && (state_q != DONE);

    assign inc[SEL_CYCLE] = cnt_en;
    for (genvar k = 0; k < NUM_EVT; k++) begin : g_inc
        assign inc[k+1] = cnt_en & evt_i[k] & ~evt_veto_i[k];
    end

    for (genvar k = 0; k <= NUM_EVT; k++) begin : g_cnt
        perf_sat_counter #(.W(CNT_W)) u_cnt (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .clr_i   (clear_i),
            .en_i    (inc[k]),
            .cnt_o   (cnt[k]),
            .ovf_o   (ovf_o[k])
        );
    end

    // Budget reached on the edge whose increment lands on MAX_CYCLES.
    assign hit_max = (MAX_CYCLES != 0) && cnt_en && !(&cnt[SEL_CYCLE]) &&
                     ((cnt[SEL_CYCLE] + CNT_W'(1)) == MAX_W);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (clear_i) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, PAUSE: begin
                    if (start_i) begin
                        state_q   <= hit_max ? DONE : RUN;
                        running_q <= !hit_max;
                        done_q    <= hit_max;
                    end
                end
                RUN: begin
                    if (!start_i) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end else if (hit_max) begin
                        state_q   <= DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                default: ; // DONE holds until clear or reset
            endcase
        end
    end

`ifdef PERF_SNAPSHOT_EN
    logic [NUM_EVT:0][CNT_W-1:0] shadow_q;

    // Captures the counters as they were before this edge's increment.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     shadow_q <= '0;
        else if (clear_i) shadow_q <= '0;
        else if (snap_i)  shadow_q <= cnt;
    end

    assign src = shadow_q;
`else
    assign src = cnt;
`endif

    always_comb begin
        rd_data_d = '0;
        if (int'(rd_sel_i) <= NUM_EVT) rd_data_d = src[rd_sel_i];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     rd_data_q <= '0;
        else if (clear_i) rd_data_q <= '0;
        else              rd_data_q <= rd_data_d;
    end

    assign rd_data_o = rd_data_q;
    assign running_o = running_q;
    assign done_o    = done_q;

endmodule
